// File: rtl/margin_bram_loader.sv
// Streams one frame of 32-bit words into BRAM port A as packed rows. Once the
// last row is written it kicks the margin controller and waits for that run
// to complete, then pulses Done and re-arms for the next frame.
module margin_bram_loader #(
    parameter int DATA_LENGTH   = 160,
    parameter int WORDS_PER_ROW = 8,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    output logic [ADDR_WIDTH-1:0]        BramAddrA,
    output logic [32*WORDS_PER_ROW-1:0]  BramDinA,
    output logic                         BramEnA,
    output logic [4*WORDS_PER_ROW-1:0]   BramWeA,
    output logic                         Start,
    input  logic                         Ready,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Err
);
    localparam int BEAT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        FLUSH   = 3'd1,
        KICK    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t                      state;
    state_t                      stateNext;
    logic [BEAT_W-1:0]           beatCnt;
    logic [ADDR_WIDTH-1:0]       rowCnt;
    logic [31:0]                 rowBuf [WORDS_PER_ROW];
    logic [32*WORDS_PER_ROW-1:0] packedRow;
    logic                        handshake;
    logic                        rowDone;
    logic                        frameDone;

    assign handshake = s_tvalid && s_tready;
    assign rowDone   = handshake && (beatCnt == LAST_BEAT);
    assign frameDone = rowDone && (rowCnt == LAST_ROW);

    // The beat being accepted right now is merged straight into the row so the
    // final beat does not need its own buffer slot before the write.
    generate
        for (genvar gi = 0; gi < WORDS_PER_ROW; gi++) begin : g_pack
            assign packedRow[32*gi +: 32] = (beatCnt == BEAT_W'(gi)) ? s_tdata : rowBuf[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; an early tlast keeps us in LOAD (counters restart).
    always_comb begin
        stateNext = state;
        case (state)
            LOAD:    if (frameDone) stateNext = FLUSH;
            FLUSH:   stateNext = KICK;
            KICK:    if (Ready) stateNext = WAIT_LO;
            WAIT_LO: if (!Ready) stateNext = WAIT_HI;
            WAIT_HI: if (Ready) stateNext = LOAD;
            default: stateNext = LOAD;
        endcase
    end

    // Combinational outputs: stream ready, controller kick and busy flag.
    always_comb begin
        s_tready = (state == LOAD);
        Start    = (state == KICK) && Ready;
        Busy     = (state != LOAD) || (beatCnt != '0) || (rowCnt != '0);
    end

    // Beat staging for the row under construction; no reset needed.
    always_ff @(posedge clk) begin
        if (handshake && !rowDone) begin
            rowBuf[beatCnt] <= s_tdata;
        end
    end

    // Counters, registered BRAM write port, Done pulse and sticky Err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beatCnt   <= '0;
            rowCnt    <= '0;
            BramEnA   <= 1'b0;
            BramWeA   <= '0;
            BramAddrA <= '0;
            BramDinA  <= '0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            BramEnA <= 1'b0;
            BramWeA <= '0;
            Done    <= 1'b0;

            if (state == WAIT_HI && Ready) begin
                Done    <= 1'b1;
                beatCnt <= '0;
                rowCnt  <= '0;
            end

            if (handshake) begin
                if (frameDone) begin
                    // Frame is length-delimited: a missing tlast is flagged
                    // but the last row is still written.
                    BramEnA   <= 1'b1;
                    BramWeA   <= '1;
                    BramAddrA <= rowCnt;
                    BramDinA  <= packedRow;
                    beatCnt   <= '0;
                    rowCnt    <= '0;
                    if (!s_tlast) begin
                        Err <= 1'b1;
                    end
                end else if (s_tlast) begin
                    // Short frame: drop the partial row and restart at row 0.
                    Err     <= 1'b1;
                    beatCnt <= '0;
                    rowCnt  <= '0;
                end else if (rowDone) begin
                    BramEnA   <= 1'b1;
                    BramWeA   <= '1;
                    BramAddrA <= rowCnt;
                    BramDinA  <= packedRow;
                    beatCnt   <= '0;
                    rowCnt    <= rowCnt + 1'b1;
                end else begin
                    beatCnt <= beatCnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_margin_bram_loader.sv
// Self-checking bench for margin_bram_loader: frames of stream words are
// compared row by row against rows rebuilt from the sent words, and the
// Start/Done handshake is checked against a simple controller model.
`timescale 1ns/1ps
module tb_margin_bram_loader;
    localparam int DL     = 160;
    localparam int WPR    = 8;
    localparam int AW     = 8;
    localparam int NBEATS = DL * WPR;
    localparam int READY_LOW_CYCLES = 1345;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [AW-1:0]     BramAddrA;
    logic [32*WPR-1:0] BramDinA;
    logic              BramEnA;
    logic [4*WPR-1:0]  BramWeA;
    logic              Start;
    logic              Ready;
    logic              Busy;
    logic              Done;
    logic              Err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    margin_bram_loader #(.DATA_LENGTH(DL), .WORDS_PER_ROW(WPR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .BramAddrA(BramAddrA), .BramDinA(BramDinA), .BramEnA(BramEnA), .BramWeA(BramWeA),
        .Start(Start), .Ready(Ready), .Busy(Busy), .Done(Done), .Err(Err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: Ready drops the cycle after Start and returns later.
    bit   ctrlAuto    = 1'b1;
    logic manualReady = 1'b1;
    logic modelReady  = 1'b1;
    int   readyRiseCyc = -1;
    assign Ready = ctrlAuto ? modelReady : manualReady;

    always @(negedge clk) begin
        if (ctrlAuto && Start) begin
            @(posedge clk); #1 modelReady = 1'b0;
            repeat (READY_LOW_CYCLES) @(posedge clk);
            #1 modelReady = 1'b1;
            readyRiseCyc = cyc;
        end
    end

    // Monitor: log BRAM writes, Start and Done activity.
    typedef struct {
        logic [AW-1:0]     addr;
        logic [32*WPR-1:0] data;
        logic [4*WPR-1:0]  we;
    } wr_t;
    wr_t wrQ[$];
    int startCnt = 0, startCyc = -1, startRun = 0, maxStartRun = 0;
    int doneCnt = 0, doneCyc = -1;

    always @(negedge clk) begin
        if (BramEnA) wrQ.push_back('{BramAddrA, BramDinA, BramWeA});
        if (Start) begin
            startCnt <= startCnt + 1;
            startCyc <= cyc;
            startRun <= startRun + 1;
            if (startRun + 1 > maxStartRun) maxStartRun <= startRun + 1;
        end else begin
            startRun <= 0;
        end
        if (Done) begin
            doneCnt <= doneCnt + 1;
            doneCyc <= cyc;
        end
    end

    logic [31:0] frameData [NBEATS];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic randomFrame();
        for (int i = 0; i < NBEATS; i++) frameData[i] = $urandom;
    endtask

    // Drives beats 0..nBeats-1 of frameData; tlastAt < 0 means no tlast.
    task automatic sendBeats(input int nBeats, input int tlastAt, input int gapPct,
                             output int stalls, output int lastHsCyc);
        bit hs;
        int w;
        stalls = 0;
        lastHsCyc = -1;
        for (int i = 0; i < nBeats; i++) begin
            while (gapPct > 0 && $urandom_range(99) < gapPct) begin
                s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = $urandom;
                tick(1);
            end
            s_tdata = frameData[i]; s_tlast = (i == tlastAt); s_tvalid = 1'b1;
            w = 0;
            do begin
                @(negedge clk); hs = s_tready; lastHsCyc = cyc;
                tick(1); w++;
            end while (!hs && w < 100);
            if (!hs) stalls++;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    // Observes until Done, counting cycles where s_tready or !Busy showed up.
    task automatic waitDone(input int budget, output bit got, output int trdyHigh, output int busyLow);
        got = 1'b0; trdyHigh = 0; busyLow = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (Done) got = 1'b1;
            else begin
                if (s_tready) trdyHigh++;
                if (!Busy) busyLow++;
            end
            tick(1);
        end
    endtask

    function automatic logic [32*WPR-1:0] expRow(input int r);
        logic [32*WPR-1:0] v;
        for (int k = 0; k < WPR; k++) v[32*k +: 32] = frameData[r*WPR + k];
        return v;
    endfunction

    // Counts logged writes from index w0 that disagree with rows 0..n-1.
    function automatic int badRows(input int w0, input int n);
        int bad = 0;
        for (int r = 0; r < n; r++) begin
            if (w0 + r >= wrQ.size()) bad++;
            else if (wrQ[w0+r].addr !== AW'(r) || wrQ[w0+r].data !== expRow(r) || wrQ[w0+r].we !== '1) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({s_tready, Busy, Err, Start, Done, BramEnA} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got tready,busy,err,start,done,en=%b expected 100000",
                     {s_tready, Busy, Err, Start, Done, BramEnA});
        end
        checks++;
        if (BramWeA !== '0 || BramAddrA !== '0 || BramDinA !== '0) begin
            errors++;
            $display("FAIL reset_bram: got we=%h addr=%0d expected all zero", BramWeA, BramAddrA);
        end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got tready=%b busy=%b expected 1 0", s_tready, Busy);
        end
        tick(1);
    endtask

    task automatic test_full_frame();
        int stalls, hsCyc, w0, s0, d0, trdyHigh, busyLow, bad;
        bit got;
        logic [32*WPR-1:0] row0;
        row0 = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        for (int i = 0; i < NBEATS; i++) frameData[i] = i;
        w0 = wrQ.size(); s0 = startCnt; d0 = doneCnt;
        sendBeats(NBEATS, NBEATS-1, 0, stalls, hsCyc);
        waitDone(3000, got, trdyHigh, busyLow);
        tick(5);
        bad = badRows(w0, DL);
        checks++;
        if (stalls !== 0) begin errors++; $display("FAIL full_stalls: got %0d expected 0", stalls); end
        checks++;
        if (wrQ.size() - w0 !== DL) begin errors++; $display("FAIL full_write_count: got %0d expected %0d", wrQ.size() - w0, DL); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL full_rows: got %0d bad rows expected 0", bad); end
        checks++;
        if (wrQ.size() > w0 && wrQ[w0].data !== row0) begin errors++; $display("FAIL full_row0: got %h expected %h", wrQ[w0].data, row0); end
        checks++;
        if (wrQ.size() >= w0 + DL && (wrQ[w0+DL-1].data[31:0] !== 32'd1272 || wrQ[w0+DL-1].addr !== AW'(159))) begin
            errors++;
            $display("FAIL full_row159: got word0=%0d addr=%0d expected 1272 159", wrQ[w0+DL-1].data[31:0], wrQ[w0+DL-1].addr);
        end
        checks++;
        if (startCnt - s0 !== 1) begin errors++; $display("FAIL full_start_count: got %0d expected 1", startCnt - s0); end
        checks++;
        if (startCyc !== hsCyc + 2) begin errors++; $display("FAIL full_start_time: got cycle %0d expected %0d", startCyc, hsCyc + 2); end
        checks++;
        if (Err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", Err); end
        checks++;
        if (!got || doneCnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", doneCnt - d0); end
        checks++;
        if (doneCyc !== readyRiseCyc + 1) begin errors++; $display("FAIL full_done_time: got cycle %0d expected %0d", doneCyc, readyRiseCyc + 1); end
        checks++;
        if (trdyHigh !== 0 || busyLow !== 0) begin errors++; $display("FAIL full_run_flags: got tready-high=%0d busy-low=%0d cycles expected 0 0", trdyHigh, busyLow); end
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL full_rearm: got tready=%b busy=%b expected 1 0", s_tready, Busy); end
        tick(1);
    endtask

    task automatic test_early_tlast();
        int stalls, hsCyc, w0, s0, d0, trdyHigh, busyLow, bad;
        bit got;
        randomFrame();
        w0 = wrQ.size(); s0 = startCnt;
        sendBeats(14, 13, 0, stalls, hsCyc);
        tick(10);
        @(negedge clk);
        checks++;
        if (Err !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL early_flags: got err=%b busy=%b expected 1 0", Err, Busy); end
        checks++;
        if (wrQ.size() - w0 !== 1 || badRows(w0, 1) !== 0) begin errors++; $display("FAIL early_writes: got %0d writes expected 1 (row 0)", wrQ.size() - w0); end
        checks++;
        if (startCnt - s0 !== 0) begin errors++; $display("FAIL early_start: got %0d expected 0", startCnt - s0); end
        tick(1);
        randomFrame();
        w0 = wrQ.size(); s0 = startCnt; d0 = doneCnt;
        sendBeats(NBEATS, NBEATS-1, 0, stalls, hsCyc);
        waitDone(3000, got, trdyHigh, busyLow);
        tick(3);
        bad = badRows(w0, DL);
        checks++;
        if (wrQ.size() - w0 !== DL || bad !== 0) begin errors++; $display("FAIL early_next_rows: got %0d writes %0d bad expected %0d 0", wrQ.size() - w0, bad, DL); end
        checks++;
        if (startCnt - s0 !== 1 || doneCnt - d0 !== 1 || !got) begin errors++; $display("FAIL early_next_run: got start=%0d done=%0d expected 1 1", startCnt - s0, doneCnt - d0); end
        checks++;
        if (Err !== 1'b1) begin errors++; $display("FAIL early_err_sticky: got %b expected 1", Err); end
    endtask

    task automatic test_reset_midframe();
        int stalls, hsCyc, w0, s0, d0, trdyHigh, busyLow, bad;
        bit got;
        randomFrame();
        sendBeats(600, -1, 50, stalls, hsCyc);
        s_tdata = frameData[600]; s_tvalid = 1'b1; rst_n = 1'b0;
        tick(2);
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_tready, Busy, Err, Start, Done, BramEnA} !== 6'b100000 || BramWeA !== '0 || BramAddrA !== '0 || BramDinA !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got tready,busy,err,start,done,en=%b addr=%0d expected 100000 0",
                     {s_tready, Busy, Err, Start, Done, BramEnA}, BramAddrA);
        end
        tick(1);
        rst_n = 1'b1;
        w0 = wrQ.size(); s0 = startCnt; d0 = doneCnt;
        tick(50);
        checks++;
        if (wrQ.size() - w0 !== 0 || startCnt - s0 !== 0 || doneCnt - d0 !== 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got writes=%0d start=%0d done=%0d busy=%b expected 0 0 0 0",
                     wrQ.size() - w0, startCnt - s0, doneCnt - d0, Busy);
        end
        randomFrame();
        sendBeats(NBEATS, NBEATS-1, 50, stalls, hsCyc);
        waitDone(3000, got, trdyHigh, busyLow);
        tick(3);
        bad = badRows(w0, DL);
        checks++;
        if (wrQ.size() - w0 !== DL || bad !== 0) begin errors++; $display("FAIL midreset_rows: got %0d writes %0d bad expected %0d 0", wrQ.size() - w0, bad, DL); end
        checks++;
        if (startCnt - s0 !== 1 || doneCnt - d0 !== 1 || !got || Err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_run: got start=%0d done=%0d err=%b expected 1 1 0", startCnt - s0, doneCnt - d0, Err);
        end
    endtask

    task automatic test_missing_tlast();
        int stalls, hsCyc, w0, s0, d0, trdyHigh, busyLow, bad;
        bit got;
        doReset();
        randomFrame();
        w0 = wrQ.size(); s0 = startCnt; d0 = doneCnt;
        sendBeats(NBEATS, -1, 0, stalls, hsCyc);
        waitDone(3000, got, trdyHigh, busyLow);
        tick(3);
        bad = badRows(w0, DL);
        checks++;
        if (Err !== 1'b1) begin errors++; $display("FAIL notlast_err: got %b expected 1", Err); end
        checks++;
        if (startCnt - s0 !== 1 || doneCnt - d0 !== 1 || !got) begin errors++; $display("FAIL notlast_run: got start=%0d done=%0d expected 1 1", startCnt - s0, doneCnt - d0); end
        checks++;
        if (wrQ.size() - w0 !== DL || bad !== 0) begin errors++; $display("FAIL notlast_rows: got %0d writes %0d bad expected %0d 0", wrQ.size() - w0, bad, DL); end
    endtask

    task automatic test_ready_low();
        int stalls, hsCyc, s0, d0, riseCyc, trdyHigh, busyLow;
        bit got;
        doReset();
        manualReady = 1'b1;
        ctrlAuto = 1'b0;
        manualReady = 1'b0;
        randomFrame();
        s0 = startCnt; d0 = doneCnt;
        sendBeats(NBEATS, NBEATS-1, 0, stalls, hsCyc);
        tick(20);
        @(negedge clk);
        checks++;
        if (startCnt - s0 !== 0 || Start !== 1'b0 || Busy !== 1'b1 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL rdylow_hold: got starts=%0d busy=%b tready=%b expected 0 1 0", startCnt - s0, Busy, s_tready);
        end
        tick(1);
        manualReady = 1'b1;
        riseCyc = cyc;
        tick(5);
        checks++;
        if (startCnt - s0 !== 1 || startCyc !== riseCyc) begin
            errors++;
            $display("FAIL rdylow_start: got count=%0d cycle=%0d expected 1 %0d", startCnt - s0, startCyc, riseCyc);
        end
        checks++;
        if (maxStartRun !== 1) begin errors++; $display("FAIL start_width: got %0d cycles expected 1", maxStartRun); end
        manualReady = 1'b0;
        tick(3);
        manualReady = 1'b1;
        riseCyc = cyc;
        waitDone(100, got, trdyHigh, busyLow);
        tick(3);
        checks++;
        if (!got || doneCnt - d0 !== 1 || doneCyc !== riseCyc + 1) begin
            errors++;
            $display("FAIL rdylow_done: got count=%0d cycle=%0d expected 1 %0d", doneCnt - d0, doneCyc, riseCyc + 1);
        end
        ctrlAuto = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        test_reset();
        test_full_frame();
        test_early_tlast();
        test_reset_midframe();
        test_missing_tlast();
        test_ready_low();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
